// File: rtl/alu_op_sequencer_if.sv
// Command and response channels between the command source and the ALU op sequencer.
// The master drives commands and consumes responses; the slave is the sequencer.
interface alu_op_sequencer_if #(
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic          cmd_useb;
    logic [DW-1:0] cmd_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_useb, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_useb, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences the ALU operation mux: one command at a time, waits the ALU settle latency,
// commits operand/store writeback per opcode and returns the result on a response channel.
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | opcode/operands stable on the ALU, counting down the settle latency
// RESP  | result held on the response channel until consumed
module alu_op_sequencer #(
    parameter int DW      = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus,
    output logic [3:0]         alu_sel,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    input  logic [DW-1:0]      alu_y,
    output logic [DW-1:0]      sto_data,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_STO  = 4'hD;
    localparam logic [3:0] OP_SWP  = 4'hE;
    localparam logic [3:0] OP_LOAD = 4'hF;
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      op_q;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   sto_q;
    logic [3:0]      sel_q;
    logic [3:0]      lat_cnt;
    logic [DW-1:0]   res_data_q;
    logic            res_zero_q;
    logic            res_valid_q;
    logic [CNT_W-1:0] op_count_q;

    logic            accept;
    logic            commit;
    logic            retire;
    logic [DW-1:0]   a_wb;
    logic [DW-1:0]   b_wb;
    logic [DW-1:0]   sto_wb;
    logic [DW-1:0]   res_wb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback values as seen at the commit edge; alu_y is sampled here.
    always_comb begin
        a_wb   = alu_y;
        b_wb   = b_q;
        sto_wb = sto_q;
        res_wb = alu_y;
        case (op_q)
            OP_CMP: a_wb = a_q;
            OP_STO: begin
                a_wb   = a_q;
                sto_wb = a_q;
                res_wb = a_q;
            end
            OP_SWP: begin
                a_wb   = b_q;
                b_wb   = a_q;
                res_wb = b_q;
            end
            OP_LOAD: begin
                a_wb   = data_q;
                res_wb = data_q;
            end
            default: a_wb = alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            data_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sto_q       <= '0;
            sel_q       <= '0;
            lat_cnt     <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                data_q  <= bus.cmd_data;
                sel_q   <= bus.cmd_op;
                lat_cnt <= LAT_INIT;
                if (bus.cmd_useb && (bus.cmd_op != OP_LOAD)) begin
                    b_q <= bus.cmd_data;
                end
            end else if ((state_q == EXEC) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (commit) begin
                a_q         <= a_wb;
                b_q         <= b_wb;
                sto_q       <= sto_wb;
                res_data_q  <= res_wb;
                res_zero_q  <= (res_wb == '0);
                res_valid_q <= 1'b1;
            end
            if (retire) begin
                res_valid_q <= 1'b0;
                op_count_q  <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready = rst_n && (state_q == IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign alu_sel       = sel_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign sto_data      = sto_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at latency 1 (16-bit counter),
// one at latency 3 with a 4-bit counter so the retire counter wrap is reachable quickly.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1;
    logic rst_n3;

    alu_op_sequencer_if #(.DW(8)) if1 ();
    alu_op_sequencer_if #(.DW(8)) if3 ();

    logic [3:0]  sel1, sel3;
    logic [7:0]  a1, b1, y1, sto1;
    logic [7:0]  a3, b3, y3, sto3;
    logic        busy1, busy3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] alu_model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        case (s)
            4'h0: y = a + b;
            4'h1: y = a - b;
            4'h2: y = a << 1;
            4'h3: y = a >> 1;
            4'h4: y = a - b;
            4'h5: y = a & b;
            4'h6: y = a | b;
            4'h7: y = a ^ b;
            4'h8: y = ~(a & b);
            4'h9: y = ~(a | b);
            4'hA: y = ~(a ^ b);
            4'hB: y = ~a;
            4'hC: y = 8'd0 - a;
            default: y = a;
        endcase
        return y;
    endfunction

    assign y1 = alu_model(sel1, a1, b1);
    assign y3 = alu_model(sel3, a3, b3);

    alu_op_sequencer #(.DW(8), .ALU_LAT(1), .CNT_W(16)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n1),
        .bus      (if1),
        .alu_sel  (sel1),
        .alu_a    (a1),
        .alu_b    (b1),
        .alu_y    (y1),
        .sto_data (sto1),
        .busy     (busy1),
        .op_count (cnt1)
    );

    alu_op_sequencer #(.DW(8), .ALU_LAT(3), .CNT_W(4)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n3),
        .bus      (if3),
        .alu_sel  (sel3),
        .alu_a    (a3),
        .alu_b    (b3),
        .alu_y    (y3),
        .sto_data (sto3),
        .busy     (busy3),
        .op_count (cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command on instance d (1 or 3), wait for the response and retire it.
    task automatic send(input int d, input logic [3:0] op, input logic useb, input logic [7:0] data,
                        input int exp_lat, input logic [7:0] exp_res, input logic exp_zero, input string tag);
        int n;
        @(negedge clk);
        if (d == 1) begin
            chk({tag, "_rdy"}, if1.cmd_ready, 1);
            if1.cmd_op = op; if1.cmd_useb = useb; if1.cmd_data = data; if1.cmd_valid = 1'b1;
        end else begin
            chk({tag, "_rdy"}, if3.cmd_ready, 1);
            if3.cmd_op = op; if3.cmd_useb = useb; if3.cmd_data = data; if3.cmd_valid = 1'b1;
        end
        @(negedge clk);
        if (d == 1) if1.cmd_valid = 1'b0;
        else        if3.cmd_valid = 1'b0;
        n = 0;
        while (!((d == 1) ? if1.res_valid : if3.res_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_res"}, (d == 1) ? if1.res_data : if3.res_data, exp_res);
        chk({tag, "_zero"}, (d == 1) ? if1.res_zero : if3.res_zero, exp_zero);
        if (d == 1) if1.res_ready = 1'b1;
        else        if3.res_ready = 1'b1;
        @(negedge clk);
        if1.res_ready = 1'b0;
        if3.res_ready = 1'b0;
        chk({tag, "_ret"}, (d == 1) ? if1.res_valid : if3.res_valid, 0);
    endtask

    initial begin
        int n;
        if1.cmd_valid = 0; if1.cmd_op = 0; if1.cmd_useb = 0; if1.cmd_data = 0; if1.res_ready = 0;
        if3.cmd_valid = 0; if3.cmd_op = 0; if3.cmd_useb = 0; if3.cmd_data = 0; if3.res_ready = 0;
        rst_n1 = 1'b0;
        rst_n3 = 1'b0;

        // Reset: two cycles low, then everything zero and ready immediately.
        if1.cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready_low", if1.cmd_ready, 0);
        if1.cmd_valid = 1'b0;
        rst_n1 = 1'b1;
        rst_n3 = 1'b1;
        #1;
        chk("rst_cmd_ready", if1.cmd_ready, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_resp", {if1.res_valid, if1.res_zero, if1.res_data}, 0);
        chk("rst_regs", {sel1, a1, b1, sto1}, 0);
        chk("rst_count", cnt1, 0);

        // LOAD then ADD.
        send(1, 4'hF, 1'b0, 8'h05, 1, 8'h05, 1'b0, "load5");
        send(1, 4'h0, 1'b1, 8'h03, 1, 8'h08, 1'b0, "add3");
        chk("add_a", a1, 8'h08);
        chk("add_b", b1, 8'h03);
        chk("add_count", cnt1, 2);

        // SUB to zero, then CMP leaves A alone.
        send(1, 4'h1, 1'b1, 8'h08, 1, 8'h00, 1'b1, "sub_zero");
        chk("sub_a", a1, 8'h00);
        send(1, 4'h4, 1'b0, 8'h00, 1, 8'hF8, 1'b0, "cmp");
        chk("cmp_a", a1, 8'h00);

        // A=0x12, B=0x34, then SWP and STO.
        send(1, 4'hF, 1'b1, 8'h12, 1, 8'h12, 1'b0, "load12");
        chk("load_useb_ignored", b1, 8'h08);
        send(1, 4'h4, 1'b1, 8'h34, 1, 8'hDE, 1'b0, "cmp_setb");
        send(1, 4'hE, 1'b0, 8'h00, 1, 8'h34, 1'b0, "swp");
        chk("swp_ab", {a1, b1}, 16'h3412);
        send(1, 4'hD, 1'b0, 8'h00, 1, 8'h34, 1'b0, "sto");
        chk("sto_data", sto1, 8'h34);
        send(1, 4'h7, 1'b1, 8'hFF, 1, 8'hCB, 1'b0, "xor");
        send(1, 4'hC, 1'b0, 8'h00, 1, 8'h35, 1'b0, "neg");
        chk("neg_a", a1, 8'h35);
        chk("count10", cnt1, 10);

        // Latency 3 with backpressure and a persistent competing command.
        @(negedge clk);
        chk("bp_rdy", if3.cmd_ready, 1);
        if3.cmd_op = 4'h0; if3.cmd_useb = 1'b1; if3.cmd_data = 8'h07; if3.cmd_valid = 1'b1;
        @(negedge clk);
        if3.cmd_op = 4'hF; if3.cmd_data = 8'hAA;
        n = 0;
        while (!if3.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_lat", n, 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", if3.res_valid, 1);
            chk("bp_data", if3.res_data, 8'h07);
            chk("bp_sel", sel3, 4'h0);
            chk("bp_cmd_ready", if3.cmd_ready, 0);
            @(negedge clk);
        end
        if3.cmd_valid = 1'b0;
        if3.res_ready = 1'b1;
        @(negedge clk);
        if3.res_ready = 1'b0;
        chk("bp_retired", if3.res_valid, 0);
        chk("bp_count", cnt3, 1);
        chk("bp_ab", {a3, b3}, 16'h0707);

        // Reset during the second EXEC cycle drops the operation.
        rst_n3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        @(negedge clk);
        if3.cmd_op = 4'h0; if3.cmd_useb = 1'b1; if3.cmd_data = 8'h09; if3.cmd_valid = 1'b1;
        @(negedge clk);
        if3.cmd_valid = 1'b0;
        chk("mid_busy", busy3, 1);
        @(negedge clk);
        rst_n3 = 1'b0;
        #1;
        chk("mid_rst_ready", if3.cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_valid", if3.res_valid, 0);
        end
        chk("mid_ab", {a3, b3}, 16'h0000);
        chk("mid_count", cnt3, 0);
        chk("mid_busy_after", busy3, 0);

        // Retire counter wrap on the 4-bit instance.
        for (int i = 0; i < 16; i++) begin
            send(3, 4'hF, 1'b0, 8'(i), 3, 8'(i), (i == 0), "wrap");
            if (i == 14) chk("wrap_max", cnt3, 4'hF);
        end
        chk("wrap_zero", cnt3, 4'h0);
        chk("wrap_a", a3, 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
